// File: rtl/masked_cache_array_if.sv
// Command/response bundle for masked_cache_array.
//   master : drives write, wmask, invalidate, index, datain; observes
//            dataout, valid_out, ready (cache controller side).
//   slave  : the storage array itself.
// width/depth must match the parameters of the attached array.
interface masked_cache_array_if #(
  parameter int width = 256,
  parameter int depth = 8
);
  localparam int idx_w = $clog2(depth);

  logic                 write;
  logic [width/8-1:0]   wmask;
  logic                 invalidate;
  logic [idx_w-1:0]     index;
  logic [width-1:0]     datain;
  logic [width-1:0]     dataout;
  logic                 valid_out;
  logic                 ready;

  modport master (
    output write, wmask, invalidate, index, datain,
    input  dataout, valid_out, ready
  );

  modport slave (
    input  write, wmask, invalidate, index, datain,
    output dataout, valid_out, ready
  );
endinterface

// File: rtl/masked_cache_array.sv
// Cache data/tag storage array with byte-masked writes, per-entry valid
// bits, an invalidate command and a post-reset clear sequencer.
//   clk        : rising-edge clock
//   rst        : asynchronous active-high reset; restarts the clear sequence
//   bus.write      : write entry[index] under wmask
//   bus.wmask      : byte enables, bit b covers datain[8b+7:8b]
//   bus.invalidate : clear valid[index]; wins over a same-cycle write
//   bus.index      : entry select shared by read, write and invalidate
//   bus.datain     : write data
//   bus.dataout    : read data (combinational or registered, see reg_read)
//   bus.valid_out  : valid bit of the read entry, aligned with dataout
//   bus.ready      : high once every entry has been zeroed
module masked_cache_array #(
  parameter int width    = 256,
  parameter int depth    = 8,
  parameter int reg_read = 0
) (
  input logic                clk,
  input logic                rst,
  masked_cache_array_if.slave bus
);
  localparam int idx_w  = $clog2(depth);
  localparam int nbytes = width / 8;

  typedef enum logic {CLEAR, READY} state_e;

  state_e             state;
  logic [idx_w-1:0]   clr_cnt;
  logic               ready_q;

  logic [width-1:0]   mem [depth];
  logic [depth-1:0]   valid;

  logic               wr_en;
  logic               inv_en;
  logic [width-1:0]   merged;
  logic               valid_next;

  // Clear sequencer: one entry zeroed per cycle, ready registered so it
  // rises on the first READY cycle.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      ready_q <= 1'b0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (clr_cnt == idx_w'(depth - 1)) begin
        state   <= READY;
        ready_q <= 1'b1;
      end
    end
  end

  assign bus.ready = ready_q;

  // Commands only take effect once the array is cleared.
  assign wr_en  = (state == READY) && bus.write;
  assign inv_en = (state == READY) && bus.invalidate;

  // Old entry with the enabled bytes replaced; feeds both the store and
  // the write-first registered read.
  // NOTE: merged gets a full default before the byte loop so no latch is
  // inferred for bytes whose enable is low.
  always_comb begin
    merged = mem[bus.index];
    for (int b = 0; b < nbytes; b++) begin
      if (bus.wmask[b]) merged[8*b +: 8] = bus.datain[8*b +: 8];
    end
  end

  // NOTE: the storage array deliberately has no reset so it can map onto a
  // RAM macro; the CLEAR sequence is what initialises it.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      mem[bus.index] <= merged;
    end
  end

  // Post-command valid bit of the addressed entry; invalidate wins.
  always_comb begin
    if (inv_en)                  valid_next = 1'b0;
    else if (wr_en && |bus.wmask) valid_next = 1'b1;
    else                         valid_next = valid[bus.index];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= '0;
    end else begin
      valid[bus.index] <= valid_next;
    end
  end

  generate
    if (reg_read != 0) begin : g_reg_read
      // Write-first: a same-cycle write to the read index is captured.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          bus.dataout   <= '0;
          bus.valid_out <= 1'b0;
        end else begin
          bus.dataout   <= wr_en ? merged : mem[bus.index];
          bus.valid_out <= valid_next;
        end
      end
    end else begin : g_comb_read
      // Read-old: a same-cycle write appears only after the edge.
      assign bus.dataout   = mem[bus.index];
      assign bus.valid_out = valid[bus.index];
    end
  endgenerate
endmodule

// File: doc/masked_cache_array.md
Name: masked_cache_array

Overview:
- Parametrised successor to the cache data/tag storage array.
- Generalised in width and depth, with byte-masked writes, per-entry valid bits and an invalidate port.
- Selectable combinational or registered read path.
- Built-in post-reset clear sequencer zeroes storage one entry per cycle, so the store can map to RAM macros.
- Sits inside each cache way (data and tag instances) beneath the cache controller.

Parameters:
- width, 256, bits per entry; multiple of 8.
- depth, 8, number of entries; power of 2, >= 2. idx_w = $clog2(depth).
- reg_read, 0, 0 = combinational read of storage; 1 = registered read with one-cycle latency.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, asynchronous, active-high.
- write  in  1  write strobe for the entry at index.
- wmask  in  width/8  byte enables; bit b covers datain[8b+7:8b].
- invalidate  in  1  clears valid bit of entry at index.
- index  in  idx_w  entry select, shared by read, write and invalidate.
- datain  in  width  write data.
- dataout  out  width  read data.
- valid_out  out  1  valid bit of the read entry, aligned with dataout.
- ready  out  1  high when the clear sequence is done; array accepts commands.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to CLEAR and clear counter = 0.
  - All depth valid bits = 0; ready = 0.
  - Registered dataout/valid_out = 0 (reg_read=1).
- FSM CLEAR:
  - Each clk with rst=0, writes all-zeros to entry[counter], then increments counter.
  - After writing entry depth-1, next state is READY. CLEAR therefore lasts exactly depth cycles after rst falls.
  - ready is 1 from the first cycle in READY.
  - write and invalidate are ignored while in CLEAR.
  - Reads during CLEAR return current storage contents: not guaranteed zero, but valid_out = 0.
- FSM READY:
  - Stays in READY until rst. rst at any point, including mid-CLEAR, restarts CLEAR from entry 0.
- Write (READY, write=1), at posedge:
  - entry[index] byte b <= datain byte b where wmask[b]=1; other bytes unchanged.
  - valid[index] <= 1 if any wmask bit is set.
  - write=1 with wmask=0 changes nothing.
- Invalidate (READY, invalidate=1):
  - valid[index] <= 0; data unchanged.
  - If write and invalidate are both 1 in the same cycle, data is written and valid ends at 0 (invalidate wins).
- Read, reg_read=0:
  - dataout = entry[index] and valid_out = valid[index], combinational.
  - Same-cycle write is visible only after the clock edge (read-old).
- Read, reg_read=1:
  - dataout/valid_out register the entry and valid bit at index on each posedge; one-cycle latency.
  - Write-first: if a write to index occurs the same cycle, the register captures the merged (masked) new data and the post-write valid bit, including the invalidate-wins rule.
- Index is always in range (power-of-2 depth); no wrap handling needed.
- Storage and valid bits are separate arrays; storage has no reset other than the CLEAR sequence.

Test Plan:
1. Reset/clear:
   - Stimulus: width=32, depth=8. Write 0xDEADBEEF to entry 3, pulse rst, then count cycles.
   - Required: ready=0 for exactly 8 cycles after rst falls, then 1. Entry 3 reads 0x00000000 with valid_out=0.
2. Masked write:
   - Stimulus: in READY, write 0x11223344 with wmask=4'hF to index 5, then write 0xAABBCCDD with wmask=4'b0101 to index 5.
   - Required: entry reads 0x11BB33DD, valid_out=1.
3. Invalidate priority:
   - Stimulus: write index 2 with wmask=F, then assert write and invalidate together on index 2 with data 0x0F0F0F0F.
   - Required: dataout=0x0F0F0F0F, valid_out=0.
4. Read-during-write, both modes:
   - Stimulus: index 6 holds 0x01010101; write 0x02020202 to index 6 (mask F).
   - Required, reg_read=0: dataout=0x01010101 that cycle.
   - Required, reg_read=1: dataout=0x02020202 the next cycle.
5. Reset mid-clear and ignored commands:
   - Stimulus: assert rst at clear count 4; during the following CLEAR, issue a write to index 7.
   - Required: CLEAR restarts and ready rises exactly 8 cycles after the second rst fall. Entry 7 = 0 and valid = 0 afterwards.
6. Zero-mask write:
   - Stimulus: write=1, wmask=0 to invalid index 1.
   - Required: data unchanged and valid_out stays 0.
